mem_hwm: RTL and testbench

- Parametrised successor to the lab single-write/dual-read memory unit.
- Provides one read/write port (A) and one read-only port (B) over a distributed-style array.
- Adds a write-qualified high-water-mark address, per-word valid bits, a write counter and a sequential clear engine.
- Sits between the datapath/control unit and the debug/display logic, which reads the high-water mark and counters.

---
 rtl/mem_hwm_pkg.sv | 14 +
 rtl/mem_hwm_if.sv | 32 +++
 rtl/mem_hwm_ram.sv | 76 +++++++
 rtl/mem_hwm.sv | 108 ++++++++++
 tb/tb_mem_hwm.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_hwm_pkg.sv
// Shared types and helpers for the high-water-mark memory: clear-engine states
// and the address range test used by both the write path and the read ports.
package mem_hwm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_hwm_if.sv
// Bus bundle for mem_hwm: port A read/write, port B read, clear control and
// the status outputs consumed by the debug/display logic.
interface mem_hwm_if #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    a_addr;
  logic [DW-1:0]    a_wdata;
  logic             a_we;
  logic [DW-1:0]    a_rdata;
  logic             a_vld;
  logic [AW-1:0]    b_addr;
  logic [DW-1:0]    b_rdata;
  logic             b_vld;
  logic             clr_req;
  logic             busy;
  logic [AW-1:0]    highest_add;
  logic             hwm_vld;
  logic [CNT_W-1:0] wr_count;
  logic             err;

  modport master (
    output a_addr, a_wdata, a_we, b_addr, clr_req,
    input  a_rdata, a_vld, b_rdata, b_vld, busy, highest_add, hwm_vld, wr_count, err
  );

  modport slave (
    input  a_addr, a_wdata, a_we, b_addr, clr_req,
    output a_rdata, a_vld, b_rdata, b_vld, busy, highest_add, hwm_vld, wr_count, err
  );
endinterface

// File: rtl/mem_hwm_ram.sv
// DEPTH x DW array with per-word valid bits, one write port and two read ports;
// reads are combinational or registered (read-first) depending on REG_OUT.
module mem_hwm_ram
  import mem_hwm_pkg::*;
#(
  parameter int          AW      = 8,
  parameter int          DW      = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int          REG_OUT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          wvld,
  input  logic [AW-1:0] a_addr,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] a_rdata,
  output logic          a_vld,
  output logic [DW-1:0] b_rdata,
  output logic          b_vld
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             a_in, b_in;
  logic [DW-1:0]    a_rd, b_rd;
  logic             a_v, b_v;

  // NOTE: the data array has no reset so it can map onto distributed RAM;
  // the valid bits carry the "written since reset/clear" information instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is also what makes registered reads read-first.
  always_ff @(posedge clk) begin
    if (!rst_n)  valid_q <= '0;
    else if (we) valid_q[waddr] <= wvld;
  end

  always_comb begin
    a_in = addr_in_range(32'(a_addr), DEPTH);
    b_in = addr_in_range(32'(b_addr), DEPTH);
    a_rd = a_in ? mem[a_addr] : '0;
    b_rd = b_in ? mem[b_addr] : '0;
    a_v  = a_in & valid_q[a_addr];
    b_v  = b_in & valid_q[b_addr];
  end

  if (REG_OUT != 0) begin : g_reg_out
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_rdata <= '0;
        a_vld   <= 1'b0;
        b_rdata <= '0;
        b_vld   <= 1'b0;
      end else begin
        a_rdata <= a_rd;
        a_vld   <= a_v;
        b_rdata <= b_rd;
        b_vld   <= b_v;
      end
    end
  end else begin : g_comb_out
    always_comb begin
      a_rdata = a_rd;
      a_vld   = a_v;
      b_rdata = b_rd;
      b_vld   = b_v;
    end
  end

endmodule

// File: rtl/mem_hwm.sv
// Memory with write-qualified high-water mark, saturating write counter,
// dropped-write error pulse and a one-word-per-cycle sequential clear engine.
module mem_hwm
  import mem_hwm_pkg::*;
#(
  parameter int          AW      = 8,
  parameter int          DW      = 16,
  parameter int unsigned DEPTH   = 256,
  parameter int          REG_OUT = 0,
  parameter int          CNT_W   = 16
) (
  input  logic    sys_clk,
  input  logic    rst_n,
  mem_hwm_if.slave bus
);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    highest_q;
  logic             hwm_vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             busy, clearing, clr_last;
  logic             wr_ok, wr_drop;
  logic             ram_we, ram_wvld;
  logic [AW-1:0]    ram_waddr;
  logic [DW-1:0]    ram_wdata;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.clr_req) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_last)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_CLEAR);
    clearing = busy;
  end

  assign clr_last = clearing && (ptr_q == AW'(DEPTH - 1));
  assign wr_ok    = bus.a_we && !busy && addr_in_range(32'(bus.a_addr), DEPTH);
  assign wr_drop  = bus.a_we && !wr_ok;

  // The clear engine owns the write port while busy, so user writes never collide with it.
  assign ram_we    = rst_n && (clearing || wr_ok);
  assign ram_waddr = clearing ? ptr_q : bus.a_addr;
  assign ram_wdata = clearing ? '0    : bus.a_wdata;
  assign ram_wvld  = !clearing;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      highest_q <= '0;
      hwm_vld_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= wr_drop;
      if (clearing) ptr_q <= clr_last ? '0 : ptr_q + AW'(1);
      if (clr_last) begin
        highest_q <= '0;
        hwm_vld_q <= 1'b0;
        cnt_q     <= '0;
      end else if (wr_ok) begin
        hwm_vld_q <= 1'b1;
        if (!hwm_vld_q || bus.a_addr > highest_q) highest_q <= bus.a_addr;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  mem_hwm_ram #(
    .AW     (AW),
    .DW     (DW),
    .DEPTH  (DEPTH),
    .REG_OUT(REG_OUT)
  ) u_ram (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .wvld   (ram_wvld),
    .a_addr (bus.a_addr),
    .b_addr (bus.b_addr),
    .a_rdata(bus.a_rdata),
    .a_vld  (bus.a_vld),
    .b_rdata(bus.b_rdata),
    .b_vld  (bus.b_vld)
  );

  assign bus.busy        = busy;
  assign bus.highest_add = highest_q;
  assign bus.hwm_vld     = hwm_vld_q;
  assign bus.wr_count    = cnt_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_hwm.sv
// Self-checking bench: dut0 uses defaults (combinational read), dut1 uses
// REG_OUT=1, DEPTH=200, CNT_W=4 for read-first, range and saturation cases.
module tb_mem_hwm;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mem_hwm_if #(.AW(8), .DW(16), .CNT_W(16)) bus0 ();
  mem_hwm_if #(.AW(8), .DW(16), .CNT_W(4))  bus1 ();

  mem_hwm #(.AW(8), .DW(16), .DEPTH(256), .REG_OUT(0), .CNT_W(16)) u_dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus0)
  );
  mem_hwm #(.AW(8), .DW(16), .DEPTH(200), .REG_OUT(1), .CNT_W(4)) u_dut1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  b_addr;
    logic [7:0]  e_hi;
    logic [15:0] e_cnt;
    logic        e_avld;
    logic [15:0] e_adata;
    logic        e_bvld;
    logic [15:0] e_bdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns how many addresses of dut0 read as valid, and the OR of their data.
  task automatic sweep0(output int ones, output logic [15:0] data_or);
    ones    = 0;
    data_or = '0;
    for (int i = 0; i < 256; i++) begin
      bus0.a_addr = 8'(i);
      #1;
      ones    += int'(bus0.a_vld);
      data_or |= bus0.a_rdata;
    end
  endtask

  vec_t        vecs [7];
  int          cyc;
  int          ones;
  logic [15:0] dor;

  initial begin
    vecs[0] = '{1'b1, 8'd5,   16'h1234, 8'd5,   8'd5,   16'd1, 1'b1, 16'h1234, 1'b1, 16'h1234};
    vecs[1] = '{1'b1, 8'd3,   16'hBEEF, 8'd3,   8'd5,   16'd2, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 8'd9,   16'h0001, 8'd3,   8'd9,   16'd3, 1'b1, 16'h0001, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 8'd4,   16'h0000, 8'd4,   8'd9,   16'd3, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 8'd2,   16'h00FF, 8'd9,   8'd9,   16'd4, 1'b1, 16'h00FF, 1'b1, 16'h0001};
    vecs[5] = '{1'b1, 8'd255, 16'h7777, 8'd255, 8'd255, 16'd5, 1'b1, 16'h7777, 1'b1, 16'h7777};
    vecs[6] = '{1'b0, 8'd3,   16'h0000, 8'd5,   8'd255, 16'd5, 1'b1, 16'hBEEF, 1'b1, 16'h1234};

    {bus0.a_addr, bus0.a_wdata, bus0.a_we, bus0.b_addr, bus0.clr_req} = '0;
    {bus1.a_addr, bus1.a_wdata, bus1.a_we, bus1.b_addr, bus1.clr_req} = '0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_highest",  32'(bus0.highest_add), 0);
    check("rst_hwm_vld",  32'(bus0.hwm_vld), 0);
    check("rst_wr_count", 32'(bus0.wr_count), 0);
    check("rst_busy",     32'(bus0.busy), 0);
    check("rst_err",      32'(bus0.err), 0);
    check("rst_reg_ardata", 32'(bus1.a_rdata), 0);
    check("rst_reg_avld",   32'(bus1.a_vld), 0);
    check("rst_reg_brdata", 32'(bus1.b_rdata), 0);
    check("rst_reg_bvld",   32'(bus1.b_vld), 0);

    // Read-only sweep must never move the high-water mark.
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      bus0.a_addr = 8'(i);
      bus0.b_addr = 8'(255 - i);
      tick();
      ones += int'(bus0.a_vld) + int'(bus0.b_vld);
    end
    check("sweep_vld_ones", 32'(ones), 0);
    check("sweep_highest",  32'(bus0.highest_add), 0);
    check("sweep_hwm_vld",  32'(bus0.hwm_vld), 0);

    for (int v = 0; v < 7; v++) begin
      bus0.a_we    = vecs[v].we;
      bus0.a_addr  = vecs[v].addr;
      bus0.a_wdata = vecs[v].wdata;
      bus0.b_addr  = vecs[v].b_addr;
      tick();
      bus0.a_we = 1'b0;
      #1;
      check($sformatf("vec%0d_highest", v), 32'(bus0.highest_add), 32'(vecs[v].e_hi));
      check($sformatf("vec%0d_hwm_vld", v), 32'(bus0.hwm_vld), 1);
      check($sformatf("vec%0d_wr_count", v), 32'(bus0.wr_count), 32'(vecs[v].e_cnt));
      check($sformatf("vec%0d_a_vld", v), 32'(bus0.a_vld), 32'(vecs[v].e_avld));
      if (vecs[v].e_avld) check($sformatf("vec%0d_a_rdata", v), 32'(bus0.a_rdata), 32'(vecs[v].e_adata));
      check($sformatf("vec%0d_b_vld", v), 32'(bus0.b_vld), 32'(vecs[v].e_bvld));
      if (vecs[v].e_bvld) check($sformatf("vec%0d_b_rdata", v), 32'(bus0.b_rdata), 32'(vecs[v].e_bdata));
    end

    // Registered read-first on dut1.
    bus1.a_we = 1'b1; bus1.a_addr = 8'd7; bus1.a_wdata = 16'h5555;
    tick();
    bus1.a_wdata = 16'hAAAA; bus1.b_addr = 8'd7;
    tick();
    bus1.a_we = 1'b0;
    check("rf_old_data", 32'(bus1.b_rdata), 32'h5555);
    check("rf_old_vld",  32'(bus1.b_vld), 1);
    tick();
    check("rf_new_data", 32'(bus1.b_rdata), 32'hAAAA);

    // Out-of-range write and read with DEPTH=200.
    bus1.a_we = 1'b1; bus1.a_addr = 8'd210; bus1.a_wdata = 16'hDEAD;
    tick();
    bus1.a_we = 1'b0;
    check("oor_err",      32'(bus1.err), 1);
    check("oor_wr_count", 32'(bus1.wr_count), 2);
    check("oor_highest",  32'(bus1.highest_add), 7);
    check("oor_rdata",    32'(bus1.a_rdata), 0);
    check("oor_vld",      32'(bus1.a_vld), 0);
    tick();
    check("oor_err_once", 32'(bus1.err), 0);
    check("oor_rdata2",   32'(bus1.a_rdata), 0);

    // Counter saturation with CNT_W=4.
    for (int i = 0; i < 20; i++) begin
      bus1.a_we = 1'b1; bus1.a_addr = 8'(10 + i); bus1.a_wdata = 16'(i);
      tick();
    end
    bus1.a_we = 1'b0; bus1.b_addr = 8'd29;
    tick();
    check("sat_wr_count", 32'(bus1.wr_count), 15);
    check("sat_highest",  32'(bus1.highest_add), 29);
    check("sat_b_rdata",  32'(bus1.b_rdata), 32'h13);
    check("sat_b_vld",    32'(bus1.b_vld), 1);

    // Clear with a simultaneous accepted write, a dropped write and a repeat request.
    bus0.a_we = 1'b1; bus0.a_addr = 8'd100; bus0.a_wdata = 16'h4242; bus0.clr_req = 1'b1;
    tick();
    bus0.a_we = 1'b0; bus0.clr_req = 1'b0;
    check("clr_write_landed", 32'(bus0.a_vld), 1);
    check("clr_write_count",  32'(bus0.wr_count), 6);
    cyc = 0;
    while (bus0.busy === 1'b1 && cyc < 1000) begin
      if (cyc == 21) check("clr_err_pulse", 32'(bus0.err), 1);
      if (cyc == 22) check("clr_err_once",  32'(bus0.err), 0);
      if (cyc == 3) begin
        bus0.b_addr = 8'd255;
        #1;
        check("clr_partial_vld",  32'(bus0.b_vld), 1);
        check("clr_partial_data", 32'(bus0.b_rdata), 32'h7777);
      end
      bus0.a_we    = (cyc == 20);
      bus0.a_addr  = 8'd5;
      bus0.a_wdata = 16'h9999;
      bus0.clr_req = (cyc == 100);
      cyc++;
      tick();
    end
    bus0.a_we = 1'b0; bus0.clr_req = 1'b0;
    check("clr_busy_len",  32'(cyc), 256);
    check("clr_highest",   32'(bus0.highest_add), 0);
    check("clr_hwm_vld",   32'(bus0.hwm_vld), 0);
    check("clr_wr_count",  32'(bus0.wr_count), 0);
    sweep0(ones, dor);
    check("clr_all_vld",   32'(ones), 0);
    check("clr_all_data",  32'(dor), 0);

    // Reset in the middle of a clear.
    bus0.a_we = 1'b1; bus0.a_addr = 8'd200; bus0.a_wdata = 16'h1111;
    tick();
    bus0.a_we = 1'b0;
    check("mid_pre_count", 32'(bus0.wr_count), 1);
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    cyc = 0;
    while (bus0.busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
    end
    check("mid_reached_100", 32'(cyc), 100);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", 32'(bus0.busy), 0);
    rst_n = 1'b1;
    check("mid_rst_count", 32'(bus0.wr_count), 0);
    check("mid_rst_hwm",   32'(bus0.hwm_vld), 0);
    check("mid_rst_dut1_count", 32'(bus1.wr_count), 0);
    sweep0(ones, dor);
    check("mid_rst_all_vld", 32'(ones), 0);

    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    cyc = 0;
    while (bus0.busy === 1'b1 && cyc < 1000) begin
      cyc++;
      tick();
    end
    check("reclr_busy_len", 32'(cyc), 256);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
